pipe_hazard_fwd_ctrl: RTL and testbench

Parametrised hazard, forwarding and stall controller for the ARM pipeline. It replaces the separate hazard-detection and forwarding units, and the glue that derives freeze and flush.
- Keeps its own shadow pipeline of destination tags for the post-ID stages.
- Generalises to NUM_SRC source operands and NUM_STAGES post-ID stages.
- Generates load-use stalls, youngest-first forward selects, freeze and flush, with memory-wait (SRAM ready) stalls.

---
 rtl/pipe_hazard_fwd_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_fwd_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_fwd_ctrl_fwd_select.sv | 29 ++
 rtl/pipe_hazard_fwd_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_hazard_fwd_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_fwd_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: default register
// address width, stage indices and the shadow-pipeline entry layout.
package pipe_ctrl_pkg;

    localparam int REG_AW  = 4;
    localparam int STG_EXE = 0;
    localparam int STG_MEM = 1;

    typedef struct packed {
        logic [REG_AW-1:0] tag;
        logic              wb;
        logic              rd;
    } tag_entry_t;

endpackage

// File: rtl/pipe_hazard_fwd_ctrl_if.sv
// ID-stage / pipeline-status bundle between the ARM pipeline and the hazard
// controller. Optional counters appear when HAZ_PERF_CNT_EN is defined.
interface pipe_hazard_fwd_ctrl_if #(
    parameter int REG_AW     = pipe_ctrl_pkg::REG_AW,
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = $clog2(NUM_STAGES)
);
    logic                      forward_enb;
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]         id_dest;
    logic                      id_wb_enb;
    logic                      id_mem_read;
    logic                      branch_taken_exe;
    logic                      mem_ready;
    logic                      hazard;
    logic                      freeze;
    logic                      flush;
    logic [NUM_SRC*SEL_W-1:0]  exe_fwd_sel;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]               stall_cycles;
    logic [31:0]               fwd_events;
`endif

    modport master (
        output forward_enb, id_valid, id_src, id_src_used, id_dest,
               id_wb_enb, id_mem_read, branch_taken_exe, mem_ready,
        input  hazard, freeze, flush, exe_fwd_sel
`ifdef HAZ_PERF_CNT_EN
             , stall_cycles, fwd_events
`endif
    );

    modport slave (
        input  forward_enb, id_valid, id_src, id_src_used, id_dest,
               id_wb_enb, id_mem_read, branch_taken_exe, mem_ready,
        output hazard, freeze, flush, exe_fwd_sel
`ifdef HAZ_PERF_CNT_EN
             , stall_cycles, fwd_events
`endif
    );

endinterface

// File: rtl/pipe_hazard_fwd_ctrl_fwd_select.sv
// Youngest-first producer match for one EXE source operand over stages
// MEM..WB; returns the stage index of the nearest writer, or 0 for the RF.
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = pipe_ctrl_pkg::REG_AW,
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = $clog2(NUM_STAGES)
) (
    input  logic                                enb,
    input  logic [REG_AW-1:0]                   src,
    input  logic [NUM_STAGES-1:1][REG_AW-1:0]   tag,
    input  logic [NUM_STAGES-1:1]               wb,
    output logic [SEL_W-1:0]                    sel
);

    // Scan oldest to youngest so the last hit is the youngest producer.
    always_comb begin
        sel = '0;
        if (enb) begin
            for (int k = NUM_STAGES - 1; k >= STG_MEM; k--) begin
                if (wb[k] && (tag[k] == src)) begin
                    sel = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_fwd_ctrl.sv
// Hazard, forwarding, freeze and flush controller with its own shadow pipeline
// of destination tags. Define HAZ_PERF_CNT_EN to add stall/forward counters.
module pipe_hazard_fwd_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = pipe_ctrl_pkg::REG_AW,
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_hazard_fwd_ctrl_if.slave bus
);

    logic [NUM_STAGES-1:0][REG_AW-1:0] tag_q;
    logic [NUM_STAGES-1:0]             wb_q;
    logic [NUM_STAGES-1:0]             rd_q;
    logic [NUM_SRC-1:0][REG_AW-1:0]    exe_src_q;
    logic [NUM_SRC-1:0]                exe_used_q;
    logic [NUM_SRC-1:0][SEL_W-1:0]     fwd_sel;
    logic                              hazard;
    logic                              freeze;
    logic                              load_id;
    logic                              unused_rd;

    // With forwarding, only loads too young to have data stall; without it,
    // every in-flight writer except WB (which writes the RF this cycle) stalls.
    always_comb begin
        hazard = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (bus.id_valid && bus.id_src_used[j] && wb_q[k] &&
                    (bus.id_src[j*REG_AW +: REG_AW] == tag_q[k])) begin
                    if (bus.forward_enb) begin
                        if ((k <= NUM_STAGES - 3) && rd_q[k]) hazard = 1'b1;
                    end else if (k <= NUM_STAGES - 2) begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign load_id = bus.id_valid & ~hazard & ~bus.branch_taken_exe;
    assign freeze  = hazard | ~bus.mem_ready;

    // Shadow pipeline: holds entirely while memory is busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q      <= '0;
            wb_q       <= '0;
            rd_q       <= '0;
            exe_src_q  <= '0;
            exe_used_q <= '0;
        end else if (bus.mem_ready) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                tag_q[k] <= tag_q[k-1];
                wb_q[k]  <= wb_q[k-1];
                rd_q[k]  <= rd_q[k-1];
            end
            if (load_id) begin
                tag_q[STG_EXE] <= bus.id_dest;
                wb_q[STG_EXE]  <= bus.id_wb_enb;
                rd_q[STG_EXE]  <= bus.id_mem_read;
                exe_src_q      <= bus.id_src;
                exe_used_q     <= bus.id_src_used;
            end else begin
                wb_q[STG_EXE]  <= 1'b0;
                rd_q[STG_EXE]  <= 1'b0;
                exe_used_q     <= '0;
            end
        end
    end

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_fwd
        fwd_select #(
            .REG_AW     (REG_AW),
            .NUM_STAGES (NUM_STAGES),
            .SEL_W      (SEL_W)
        ) u_fwd_select (
            .enb (bus.forward_enb & exe_used_q[j]),
            .src (exe_src_q[j]),
            .tag (tag_q[NUM_STAGES-1:STG_MEM]),
            .wb  (wb_q[NUM_STAGES-1:STG_MEM]),
            .sel (fwd_sel[j])
        );
    end

    assign bus.hazard      = hazard;
    assign bus.freeze      = freeze;
    assign bus.flush       = bus.branch_taken_exe;
    assign bus.exe_fwd_sel = fwd_sel;

    // Load flags past the last load-use stage only travel along with the tag.
    assign unused_rd = ^rd_q[NUM_STAGES-1:NUM_STAGES-2];

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (freeze && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.mem_ready && (|fwd_sel) && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.fwd_events   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_fwd_ctrl.sv
// Directed bench for pipe_hazard_fwd_ctrl: a cycle-by-cycle vector table plus
// hand-written memory-wait, flush and asynchronous-reset sequences.
module tb_pipe_hazard_fwd_ctrl;

    localparam int REG_AW     = 4;
    localparam int NUM_SRC    = 2;
    localparam int NUM_STAGES = 3;
    localparam int SEL_W      = 2;

    typedef struct {
        logic       fwd, vld;
        logic [3:0] s0, s1;
        logic [1:0] used;
        logic [3:0] dest;
        logic       wbe, mrd, br, mrdy, adv;
        logic       hz, fz, fl;
        logic [3:0] sel;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    pipe_hazard_fwd_ctrl_if #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)
    ) bus ();

    pipe_hazard_fwd_ctrl #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fwd, input logic vld, input logic [3:0] s0,
                         input logic [3:0] s1, input logic [1:0] used,
                         input logic [3:0] dest, input logic wbe, input logic mrd,
                         input logic br, input logic mrdy);
        bus.forward_enb      = fwd;
        bus.id_valid         = vld;
        bus.id_src           = {s1, s0};
        bus.id_src_used      = used;
        bus.id_dest          = dest;
        bus.id_wb_enb        = wbe;
        bus.id_mem_read      = mrd;
        bus.branch_taken_exe = br;
        bus.mem_ready        = mrdy;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic fwd, logic vld, logic [3:0] s0, logic [3:0] s1,
                                logic [1:0] used, logic [3:0] dest, logic wbe, logic mrd,
                                logic br, logic mrdy, logic adv, logic hz, logic fz,
                                logic fl, logic [3:0] sel);
        vec_t v;
        v.fwd = fwd; v.vld = vld; v.s0 = s0; v.s1 = s1; v.used = used;
        v.dest = dest; v.wbe = wbe; v.mrd = mrd; v.br = br; v.mrdy = mrdy;
        v.adv = adv; v.hz = hz; v.fz = fz; v.fl = fl; v.sel = sel;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: sel column is {sel_src1, sel_src0}, two bits each.
        // Load-use: LDR R3, then ADD R4<-R3 stalls once, then forwards from WB.
        vecs.push_back(mk(1,1,0,0,2'b00,3,1,1,0,1,1, 0,0,0,4'h0));
        vecs.push_back(mk(1,1,3,0,2'b01,4,1,0,0,1,1, 1,1,0,4'h0));
        vecs.push_back(mk(1,1,3,0,2'b01,4,1,0,0,1,1, 0,0,0,4'h0));
        vecs.push_back(mk(1,0,0,0,2'b00,0,0,0,0,1,1, 0,0,0,4'h2));
        // ALU priority: SUB R2, ADD R2, then consumer src1=R2 picks MEM.
        vecs.push_back(mk(1,1,0,0,2'b00,2,1,0,0,1,1, 0,0,0,4'h0));
        vecs.push_back(mk(1,1,0,0,2'b00,2,1,0,0,1,1, 0,0,0,4'h0));
        vecs.push_back(mk(1,1,9,2,2'b10,6,1,0,0,1,1, 0,0,0,4'h0));
        vecs.push_back(mk(0,0,0,0,2'b00,0,0,0,0,1,0, 0,0,0,4'h0));
        vecs.push_back(mk(1,0,0,0,2'b00,0,0,0,0,1,1, 0,0,0,4'h4));
        vecs.push_back(mk(1,0,0,0,2'b00,0,0,0,0,1,1, 0,0,0,4'h0));
        // No forwarding: R5 in MEM stalls, R5 in WB does not.
        vecs.push_back(mk(0,1,0,0,2'b00,5,1,0,0,1,1, 0,0,0,4'h0));
        vecs.push_back(mk(0,0,0,0,2'b00,0,0,0,0,1,1, 0,0,0,4'h0));
        vecs.push_back(mk(0,1,0,5,2'b10,8,0,0,0,1,1, 1,1,0,4'h0));
        vecs.push_back(mk(0,1,0,5,2'b10,8,0,0,0,1,1, 0,0,0,4'h0));
        vecs.push_back(mk(1,0,0,0,2'b00,0,0,0,0,1,1, 0,0,0,4'h0));

        // Reset state, asserted from time zero.
        drive(0,0,0,0,2'b00,0,0,0,0,0);
        #1;
        chk("rst_freeze_busy", 32'(bus.freeze), 32'd1);
        drive(1,0,0,0,2'b00,0,0,0,1,1);
        #1;
        chk("rst_hazard", 32'(bus.hazard), 32'd0);
        chk("rst_sel", 32'(bus.exe_fwd_sel), 32'd0);
        chk("rst_freeze_ready", 32'(bus.freeze), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd1);
        drive(1,0,0,0,2'b00,0,0,0,0,1);
        step();
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].fwd, vecs[i].vld, vecs[i].s0, vecs[i].s1, vecs[i].used,
                  vecs[i].dest, vecs[i].wbe, vecs[i].mrd, vecs[i].br, vecs[i].mrdy);
            #1;
            chk($sformatf("v%0d_hazard", i), 32'(bus.hazard), 32'(vecs[i].hz));
            chk($sformatf("v%0d_freeze", i), 32'(bus.freeze), 32'(vecs[i].fz));
            chk($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(vecs[i].fl));
            chk($sformatf("v%0d_sel", i), 32'(bus.exe_fwd_sel), 32'(vecs[i].sel));
            if (vecs[i].adv) step();
        end

        // Memory wait: ADD R7, consumer of R7 in EXE, then four busy cycles.
        drive(1,1,0,0,2'b00,7,1,0,0,1);
        step();
        drive(1,1,7,0,2'b01,9,1,0,0,1);
        #1;
        chk("mw_setup_hazard", 32'(bus.hazard), 32'd0);
        step();
        drive(1,1,0,0,2'b00,10,1,0,0,0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("mw%0d_freeze", c), 32'(bus.freeze), 32'd1);
            chk($sformatf("mw%0d_sel", c), 32'(bus.exe_fwd_sel), 32'h1);
            step();
        end
        drive(1,1,0,0,2'b00,10,1,0,0,1);
        #1;
        chk("mw_ready_freeze", 32'(bus.freeze), 32'd0);
        chk("mw_ready_sel", 32'(bus.exe_fwd_sel), 32'h1);
        step();
        drive(1,0,0,0,2'b00,0,0,0,0,1);
        #1;
        chk("mw_adv_sel", 32'(bus.exe_fwd_sel), 32'h0);
        drive(0,1,9,0,2'b01,0,0,0,0,1);
        #1;
        chk("mw_r9_in_mem", 32'(bus.hazard), 32'd1);
        drive(0,1,7,0,2'b01,0,0,0,0,1);
        #1;
        chk("mw_r7_in_wb", 32'(bus.hazard), 32'd0);

        // Branch flush: ID writer of R11 must not enter EXE.
        drive(1,1,0,0,2'b00,11,1,0,1,1);
        #1;
        chk("br_flush", 32'(bus.flush), 32'd1);
        chk("br_freeze", 32'(bus.freeze), 32'd0);
        step();
        drive(0,1,11,0,2'b01,0,0,0,0,1);
        #1;
        chk("br_bubble", 32'(bus.hazard), 32'd0);
        drive(0,1,10,0,2'b01,0,0,0,0,1);
        #1;
        chk("br_advanced", 32'(bus.hazard), 32'd1);
        // Flush during memory wait: everything holds.
        drive(0,1,0,0,2'b00,12,1,0,1,0);
        #1;
        chk("brmw_freeze", 32'(bus.freeze), 32'd1);
        chk("brmw_flush", 32'(bus.flush), 32'd1);
        step();
        drive(0,1,10,0,2'b01,0,0,0,0,1);
        #1;
        chk("brmw_held", 32'(bus.hazard), 32'd1);
        drive(0,1,12,0,2'b01,0,0,0,0,1);
        #1;
        chk("brmw_no_entry", 32'(bus.hazard), 32'd0);

        // Async reset with a live hazard and a live forward.
        drive(1,1,0,0,2'b00,1,1,0,0,1);
        step();
        drive(1,1,1,0,2'b01,3,1,1,0,1);
        #1;
        chk("ar_setup_hazard", 32'(bus.hazard), 32'd0);
        step();
        drive(1,1,3,0,2'b01,4,1,0,0,1);
        #1;
        chk("ar_pre_hazard", 32'(bus.hazard), 32'd1);
        chk("ar_pre_sel", 32'(bus.exe_fwd_sel), 32'h1);
        rst = 1'b0;
        #1;
        chk("ar_hazard", 32'(bus.hazard), 32'd0);
        chk("ar_sel", 32'(bus.exe_fwd_sel), 32'h0);
        chk("ar_freeze", 32'(bus.freeze), 32'd0);
        #1;
        rst = 1'b1;
        step();
        chk("ar_post_hazard", 32'(bus.hazard), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
